connector_rr_arbiter: RTL

- Merges the three 8-bit connector streams (ports 0, 1, 2) onto one shared output channel.
- Each port has a small FIFO. A round-robin arbiter drains the FIFOs into a registered output stage with a valid/ready handshake.
- A freeze input stalls arbitration without corrupting data already in flight.
- Sits between the per-port connector endpoints and the single downstream consumer.

---
 rtl/connector_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/connector_rr_arbiter.sv
// connector_rr_arbiter
//   Merges three DATA_W-bit connector streams onto one shared output channel.
//   Each port feeds a FIFO_DEPTH-entry FIFO. A round-robin arbiter drains the
//   FIFOs into a registered output stage with a valid/ready handshake.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid[2:0]       : per-port push request
//   in_data_0/1/2       : per-port push data
//   in_ready[2:0]       : per-port FIFO not full (forced low during reset)
//   freeze              : blocks new loads into the output stage
//   out_valid/out_data/out_port : output word, its source port
//   out_ready           : downstream accept
//   fifo_level_0/1/2    : per-port FIFO occupancy
//   grant_cnt_0/1/2     : words forwarded per port since reset (wrapping)
module connector_rr_arbiter #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        in_valid,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  output logic [2:0]        in_ready,
  input  logic              freeze,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_port,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fifo_level_0,
  output logic [LVL_W-1:0]  fifo_level_1,
  output logic [LVL_W-1:0]  fifo_level_2,
  output logic [CNT_W-1:0]  grant_cnt_0,
  output logic [CNT_W-1:0]  grant_cnt_1,
  output logic [CNT_W-1:0]  grant_cnt_2
);

  // Round-robin pick: search (last+1)%3, (last+2)%3, then last itself.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] c0, c1, c2;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req[c0])      rr_pick = c0;
    else if (req[c1]) rr_pick = c1;
    else              rr_pick = c2;
  endfunction

  logic [DATA_W-1:0] mem_q    [3][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [3];
  logic [PTR_W-1:0]  rd_ptr_q [3];
  logic [LVL_W-1:0]  level_q  [3];
  logic [CNT_W-1:0]  cnt_q    [3];
  logic [1:0]        last_grant_q, last_grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_port_q, out_port_d;

  logic [DATA_W-1:0] in_data_a [3];
  logic [DATA_W-1:0] head      [3];
  logic [2:0]        nonempty;
  logic [2:0]        push;
  logic [2:0]        pop;
  logic              slot_free;
  logic              load;
  logic [1:0]        winner;

  assign in_data_a[0] = in_data_0;
  assign in_data_a[1] = in_data_1;
  assign in_data_a[2] = in_data_2;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      head[i]     = mem_q[i][rd_ptr_q[i]];
      nonempty[i] = (level_q[i] != '0);
      // A full FIFO refuses a push even when it is popped in the same cycle.
      in_ready[i] = !rst && (level_q[i] != LVL_W'(FIFO_DEPTH));
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Stage boundary: FIFO heads -> output register.
  always_comb begin
    slot_free    = !out_valid_q || out_ready;
    load         = slot_free && !freeze && (|nonempty);
    winner       = rr_pick(last_grant_q, nonempty);
    pop          = 3'b000;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    last_grant_d = last_grant_q;
    if (load) begin
      pop[winner]  = 1'b1;
      out_valid_d  = 1'b1;
      out_data_d   = head[winner];
      out_port_d   = winner;
      last_grant_d = winner;
    end else if (slot_free) begin
      // Word consumed (or slot already empty) and nothing to load: data/port hold.
      out_valid_d = 1'b0;
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the control state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data_a[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
        cnt_q[i]    <= '0;
      end
      last_grant_q <= 2'd2;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_port_q   <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i]) begin
          rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
          cnt_q[i]    <= cnt_q[i] + CNT_W'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   level_q[i] <= level_q[i] + LVL_W'(1);
          2'b01:   level_q[i] <= level_q[i] - LVL_W'(1);
          default: level_q[i] <= level_q[i];
        endcase
      end
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_port_q   <= out_port_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_port     = out_port_q;
  assign fifo_level_0 = level_q[0];
  assign fifo_level_1 = level_q[1];
  assign fifo_level_2 = level_q[2];
  assign grant_cnt_0  = cnt_q[0];
  assign grant_cnt_1  = cnt_q[1];
  assign grant_cnt_2  = cnt_q[2];

endmodule
